mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
Single-port arbiter between the IF stage (instruction fetch) and the MEM stage (loads/stores) and the byte-wide synchronous RAM.
- Serialises each request into byte accesses and reassembles or sign-extends read data.
- Produces the if_stall and mem_stall requests consumed by the pipeline stall controller.
- Sits between the IF/MEM stages and the RAM/IO bus.

Parameters:
ADDR_WIDTH, 32, width of all address ports.
IO_BASE, 32'h30000, IO window start; addresses >= IO_BASE are IO.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
rdy  in  1  global ready; low freezes all state
if_req  in  1  fetch request, held until if_done
if_addr  in  32  fetch address (word)
if_flush  in  1  abort an in-flight fetch (branch/jump)
if_inst  out  32  fetched instruction, valid with if_done
if_done  out  1  one-cycle completion pulse
mem_req  in  1  load/store request, held until mem_done
mem_we  in  1  1=store, 0=load
mem_size  in  2  00 byte, 01 half, 10 word
mem_signed  in  1  sign-extend load result
mem_addr  in  32  data address
mem_wdata  in  32  store data, little-endian
mem_rdata  out  32  load result, valid with mem_done
mem_done  out  1  one-cycle completion pulse
if_stall  out  1  if_req & ~if_done
mem_stall  out  1  mem_req & ~mem_done
ram_din  in  8  RAM read byte
ram_dout  out  8  RAM write byte
ram_a  out  32  RAM byte address
ram_wr  out  1  1=write, 0=read
io_buffer_full  in  1  IO output buffer full

Behaviour:
- Reset (rst=1 at an edge): state IDLE; byte counter 0; ram_a=0, ram_wr=0, ram_dout=0; if_done=0, mem_done=0; if_inst=0, mem_rdata=0. Reset mid-transaction drops it silently; no done pulse follows.
- rdy=0: every register holds its value, and ram_wr is gated to 0 on the output. Reset takes precedence over rdy.
- RAM timing: the address and ram_wr registered at edge E are seen by the RAM at edge E+1; the read byte is valid on ram_din after E+1 and is captured at E+2.
- States: IDLE, IF_RD, MEM_RD, MEM_WR, WR_WAIT.
- IDLE arbitration: mem_req has priority over if_req, because MEM holds the older instruction. A started transaction is never preempted.
- Accept edge E0:
  - Latch the request.
  - ram_a <= address.
  - For stores: ram_wr <= 1 and ram_dout <= byte 0.
  - Counter <= 1.
- Reads of N bytes (IF: N=4):
  - ram_a increments each edge through byte N-1.
  - Byte k is placed at bits [8k+7:8k].
  - Done pulses in the cycle after edge E(N+1), i.e. word latency is 5 cycles from acceptance.
- Stores of N bytes:
  - Byte k is driven on ram_dout/ram_a with ram_wr=1 for one cycle each.
  - mem_done pulses after edge EN.
  - The FSM then enters WR_WAIT for one cycle (ram_wr=0), then IDLE.
- Load result: for byte and half loads, mem_rdata is zero-extended or, when mem_signed=1, sign-extended.
- No alignment checks; halves and words may straddle any byte address.
- IO stores: a store with mem_addr >= IO_BASE is not accepted while io_buffer_full=1. The FSM stays IDLE, mem_stall stays high, and no fetch is started in its place.
- if_flush=1:
  - During IF_RD: abort; IDLE at the next edge, no if_done, ram_wr stays 0.
  - In IDLE: suppresses IF acceptance that cycle.
  - Never affects MEM transactions.
- Done pulses are exactly one cycle and cleared at the next edge.
- A request still high in the cycle after done is treated as a new request.
- ram_wr is 0 in every state except MEM_WR.

Decomposition:
- config.v holds:
  - `Enable/`Disable
  - mem_size encodings (`SizeByte, `SizeHalf, `SizeWord)
  - FSM state codes
  - `IoBase
  - `AddrBus and `DataBus widths
- No sub-module is needed. Byte extraction and sign extension are a local function inside mem_ctrl.

Test Plan:
- Word fetch: RAM[0x100..0x103]=13,05,00,00; if_req at 0x100 -> if_done 5 cycles after acceptance, if_inst=0x00000513; if_stall high until the done cycle.
- Signed byte load: RAM[0x2001]=0x80, LB at 0x2001 -> mem_rdata=0xFFFFFF80; LBU at the same address -> 0x00000080; done 2 cycles after acceptance.
- Store word: SW 0xDEADBEEF at 0x400 -> ram writes EF,BE,AD,DE to 0x400..0x403 on consecutive cycles; mem_done after the 4th; one WR_WAIT cycle with ram_wr=0.
- Contention: if_req and mem_req (LW) rise together -> MEM served first; IF accepted in the cycle after mem_done; both return correct data.
- IO hold and flush:
  - SB to 0x30000 with io_buffer_full=1 for 3 cycles -> no ram_wr; write occurs after the flag drops.
  - if_flush at the 2nd IF_RD cycle -> no if_done; IDLE next cycle.
- Reset and rdy: rst mid-store -> ram_wr=0 and all outputs zero next cycle; rdy low for 2 cycles mid-read -> latency extends by exactly 2, data correct.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the IF/MEM-to-RAM byte-serialising memory controller.
package mem_ctrl_pkg;

  localparam logic Enable  = 1'b1;
  localparam logic Disable = 1'b0;

  localparam int unsigned AddrBus = 32;
  localparam int unsigned DataBus = 32;

  localparam logic [31:0] IoBase = 32'h0003_0000;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StIfRd   = 3'd1;
  localparam logic [2:0] StMemRd  = 3'd2;
  localparam logic [2:0] StMemWr  = 3'd3;
  localparam logic [2:0] StWrWait = 3'd4;

  // Unknown size codes fall back to a full word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SizeByte: return 3'd1;
      SizeHalf: return 3'd2;
      SizeWord: return 3'd4;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates IF fetches and MEM loads/stores onto a byte-wide synchronous RAM,
// one byte per cycle, and raises the matching pipeline stall requests.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = AddrBus,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(IoBase)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic [DataBus-1:0]    if_inst,
  output logic                  if_done,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [1:0]            mem_size,
  input  logic                  mem_signed,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DataBus-1:0]    mem_wdata,
  output logic [DataBus-1:0]    mem_rdata,
  output logic                  mem_done,
  output logic                  if_stall,
  output logic                  mem_stall,
  input  logic [7:0]            ram_din,
  output logic [7:0]            ram_dout,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic                  ram_wr,
  input  logic                  io_buffer_full
);

  logic [2:0]            state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] ram_a_q, ram_a_d;
  logic [1:0]            size_q, size_d;
  logic                  sign_q, sign_d;
  logic [DataBus-1:0]    wdata_q, wdata_d;
  logic [DataBus-1:0]    buf_q, buf_d;
  logic [DataBus-1:0]    if_inst_q, if_inst_d;
  logic [DataBus-1:0]    mem_rdata_q, mem_rdata_d;
  logic                  ram_wr_q, ram_wr_d;
  logic [7:0]            ram_dout_q, ram_dout_d;
  logic                  if_done_q, if_done_d;
  logic                  mem_done_q, mem_done_d;

  logic [2:0]            nbytes;
  logic [1:0]            rd_idx;
  logic [DataBus-1:0]    merged;
  logic                  mem_go, if_go, io_block;

  function automatic logic [7:0] get_byte(input logic [DataBus-1:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [DataBus-1:0] extend_load(input logic [DataBus-1:0] raw,
                                                     input logic [1:0] size, input logic sgn);
    case (size)
      SizeByte: return {{24{sgn & raw[7]}}, raw[7:0]};
      SizeHalf: return {{16{sgn & raw[15]}}, raw[15:0]};
      default:  return raw;
    endcase
  endfunction

  // A request seen in its own done cycle is the one just completed, not a new one.
  assign mem_go   = mem_req & ~mem_done_q;
  assign if_go    = if_req & ~if_done_q & ~if_flush;
  assign io_block = mem_we & (mem_addr >= IO_BASE) & io_buffer_full;

  assign nbytes = (state_q == StIfRd) ? 3'd4 : size_bytes(size_q);
  assign rd_idx = 2'(cnt_q - 3'd2);

  // Byte k arrives on ram_din two edges after its address was registered.
  always_comb begin
    merged = buf_q;
    if (cnt_q >= 3'd2) merged[{rd_idx, 3'b000} +: 8] = ram_din;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    ram_a_d     = ram_a_q;
    size_d      = size_q;
    sign_d      = sign_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    ram_wr_d    = ram_wr_q;
    ram_dout_d  = ram_dout_q;
    if_done_d   = Disable;
    mem_done_d  = Disable;

    case (state_q)
      StIdle: begin
        // An IO store held off by a full buffer still blocks fetches.
        if (mem_go) begin
          if (!io_block) begin
            addr_d  = mem_addr;
            ram_a_d = mem_addr;
            size_d  = mem_size;
            sign_d  = mem_signed;
            wdata_d = mem_wdata;
            buf_d   = '0;
            cnt_d   = 3'd1;
            if (mem_we) begin
              state_d    = StMemWr;
              ram_wr_d   = Enable;
              ram_dout_d = mem_wdata[7:0];
            end else begin
              state_d = StMemRd;
            end
          end
        end else if (if_go) begin
          addr_d  = if_addr;
          ram_a_d = if_addr;
          buf_d   = '0;
          cnt_d   = 3'd1;
          state_d = StIfRd;
        end
      end

      StIfRd, StMemRd: begin
        if (state_q == StIfRd && if_flush) begin
          state_d = StIdle;
          cnt_d   = 3'd0;
        end else begin
          buf_d = merged;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q < nbytes) ram_a_d = addr_q + ADDR_WIDTH'(cnt_q);
          if (cnt_q == nbytes + 3'd1) begin
            state_d = StIdle;
            cnt_d   = 3'd0;
            if (state_q == StIfRd) begin
              if_done_d = Enable;
              if_inst_d = merged;
            end else begin
              mem_done_d  = Enable;
              mem_rdata_d = extend_load(merged, size_q, sign_q);
            end
          end
        end
      end

      StMemWr: begin
        if (cnt_q == nbytes) begin
          ram_wr_d   = Disable;
          mem_done_d = Enable;
          state_d    = StWrWait;
          cnt_d      = 3'd0;
        end else begin
          ram_a_d    = addr_q + ADDR_WIDTH'(cnt_q);
          ram_dout_d = get_byte(wdata_q, cnt_q[1:0]);
          cnt_d      = cnt_q + 3'd1;
        end
      end

      StWrWait: state_d = StIdle;

      default: begin
        state_d  = StIdle;
        cnt_d    = 3'd0;
        ram_wr_d = Disable;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      addr_q      <= '0;
      ram_a_q     <= '0;
      size_q      <= SizeByte;
      sign_q      <= Disable;
      wdata_q     <= '0;
      buf_q       <= '0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
      ram_wr_q    <= Disable;
      ram_dout_q  <= 8'h00;
      if_done_q   <= Disable;
      mem_done_q  <= Disable;
    end else if (rdy) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      ram_a_q     <= ram_a_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign ram_wr    = ram_wr_q & rdy;
  assign if_inst   = if_inst_q;
  assign if_done   = if_done_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_done  = mem_done_q;
  assign if_stall  = if_req & ~if_done_q;
  assign mem_stall = mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-wide RAM model, vector table for loads/stores,
// hand-written sequences for arbitration, IO hold, flush, rdy and reset.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_inst;
  logic        mem_req, mem_we, mem_signed, mem_done;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        if_stall, mem_stall;
  logic [7:0]  ram_din, ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr, io_buffer_full;

  int checks = 0;
  int errors = 0;

  mem_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_flush       (if_flush),
    .if_inst        (if_inst),
    .if_done        (if_done),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_size       (mem_size),
    .mem_signed     (mem_signed),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_done       (mem_done),
    .if_stall       (if_stall),
    .mem_stall      (mem_stall),
    .ram_din        (ram_din),
    .ram_dout       (ram_dout),
    .ram_a          (ram_a),
    .ram_wr         (ram_wr),
    .io_buffer_full (io_buffer_full)
  );

  always #5 clk = ~clk;

  // RAM model; rdy freezes the whole memory system, RAM included.
  bit [7:0]    ram [0:262143];
  int          cyc = 0;
  int          wlog_n = 0;
  logic [31:0] wlog_a [0:15];
  logic [7:0]  wlog_d [0:15];
  int          wlog_c [0:15];
  int          ifdone_cnt = 0;
  int          memdone_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (if_done)  ifdone_cnt  <= ifdone_cnt + 1;
    if (mem_done) memdone_cnt <= memdone_cnt + 1;
    if (rdy) begin
      if (ram_wr) begin
        ram[ram_a[17:0]] = ram_dout;
        if (wlog_n < 16) begin
          wlog_a[wlog_n] = ram_a;
          wlog_d[wlog_n] = ram_dout;
          wlog_c[wlog_n] = cyc;
        end
        wlog_n = wlog_n + 1;
      end
      ram_din <= ram[ram_a[17:0]];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issues one MEM request; lat counts edges after the accept edge until mem_done.
  // hold_at > 0 drops rdy for two cycles starting after that many edges.
  task automatic do_mem(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold_at,
                        output int lat, output logic [31:0] rdata);
    logic got;
    mem_we = we; mem_size = size; mem_signed = sgn; mem_addr = addr; mem_wdata = wdata;
    mem_req = 1'b1;
    got = 1'b0; lat = -1; rdata = 32'hx;
    step();
    for (int s = 1; s <= 40 && !got; s++) begin
      step();
      if (mem_done) begin
        got = 1'b1;
        lat = s;
        rdata = mem_rdata;
        if (we) check("store_done_ram_wr", {31'd0, ram_wr}, 32'd0);
      end else if (hold_at != 0 && (s == hold_at || s == hold_at + 1)) begin
        rdy = 1'b0;
        #1;
        check("rdy_low_ram_wr", {31'd0, ram_wr}, 32'd0);
      end else begin
        rdy = 1'b1;
      end
    end
    rdy = 1'b1;
    mem_req = 1'b0;
    step();
    step();
  endtask

  task automatic wait_if(output int lat);
    lat = -1;
    for (int s = 1; s <= 40 && lat < 0; s++) begin
      step();
      if (if_done) lat = s;
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [0:11];

  initial begin
    int          lat;
    int          base;
    logic [31:0] rd;
    logic [7:0]  sw_bytes [0:3];

    vecs[0]  = '{1'b0, 2'b00, 1'b1, 32'h2001, 32'h0, 32'hFFFF_FF80, 2};
    vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h2001, 32'h0, 32'h0000_0080, 2};
    vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h2000, 32'h0, 32'h0000_007F, 2};
    vecs[3]  = '{1'b0, 2'b01, 1'b1, 32'h2001, 32'h0, 32'hFFFF_FF80, 3};
    vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h2001, 32'h0, 32'h0000_FF80, 3};
    vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'h2002, 32'h0, 32'h0000_01FF, 3};
    vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h2000, 32'h0, 32'h01FF_807F, 5};
    vecs[7]  = '{1'b1, 2'b01, 1'b0, 32'h0501, 32'hAAAA_1234, 32'h0, 2};
    vecs[8]  = '{1'b0, 2'b10, 1'b0, 32'h0500, 32'h0, 32'h0012_3400, 5};
    vecs[9]  = '{1'b1, 2'b00, 1'b0, 32'h0600, 32'h0000_00C3, 32'h0, 1};
    vecs[10] = '{1'b0, 2'b00, 1'b1, 32'h0600, 32'h0, 32'hFFFF_FFC3, 2};
    vecs[11] = '{1'b0, 2'b10, 1'b1, 32'h2000, 32'h0, 32'h01FF_807F, 5};

    ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
    ram[32'h2000] = 8'h7F; ram[32'h2001] = 8'h80; ram[32'h2002] = 8'hFF; ram[32'h2003] = 8'h01;

    rst = 1'b1; rdy = 1'b1; if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'b00; mem_signed = 1'b0;
    mem_addr = '0; mem_wdata = '0; io_buffer_full = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_ram_a", ram_a, 32'h0);
    check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    check("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
    check("rst_done", {30'd0, if_done, mem_done}, 32'd0);
    check("rst_if_inst", if_inst, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);

    // Word fetch, stall held through the wait.
    if_addr = 32'h100; if_req = 1'b1;
    #1;
    check("fetch_stall_pre", {31'd0, if_stall}, 32'd1);
    step();
    lat = -1;
    for (int s = 1; s <= 40 && lat < 0; s++) begin
      step();
      if (if_done) lat = s;
      else if (s == 3) check("fetch_stall_mid", {31'd0, if_stall}, 32'd1);
    end
    check("fetch_latency", lat, 5);
    check("fetch_inst", if_inst, 32'h0000_0513);
    check("fetch_stall_done", {31'd0, if_stall}, 32'd0);
    if_req = 1'b0;
    step();
    step();

    foreach (vecs[i]) begin
      do_mem(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, 0, lat, rd);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
    end

    // Store word: four byte writes on consecutive cycles.
    sw_bytes[0] = 8'hEF; sw_bytes[1] = 8'hBE; sw_bytes[2] = 8'hAD; sw_bytes[3] = 8'hDE;
    wlog_n = 0;
    do_mem(1'b1, 2'b10, 1'b0, 32'h400, 32'hDEAD_BEEF, 0, lat, rd);
    check("sw_latency", lat, 4);
    check("sw_write_count", wlog_n, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sw_addr%0d", i), wlog_a[i], 32'h400 + i);
      check($sformatf("sw_data%0d", i), {24'd0, wlog_d[i]}, {24'd0, sw_bytes[i]});
      check($sformatf("sw_cycle%0d", i), wlog_c[i] - wlog_c[0], i);
    end

    // Contention: MEM wins, IF starts right after mem_done.
    if_addr = 32'h100; if_req = 1'b1;
    mem_we = 1'b0; mem_size = 2'b10; mem_signed = 1'b0; mem_addr = 32'h2000; mem_req = 1'b1;
    step();
    check("cont_if_stall", {31'd0, if_stall}, 32'd1);
    check("cont_mem_stall", {31'd0, mem_stall}, 32'd1);
    lat = -1;
    for (int s = 1; s <= 40 && lat < 0; s++) begin
      step();
      if (mem_done) lat = s;
    end
    check("cont_mem_latency", lat, 5);
    check("cont_mem_rdata", mem_rdata, 32'h01FF_807F);
    check("cont_if_not_done", {31'd0, if_done}, 32'd0);
    mem_req = 1'b0;
    step();
    check("cont_if_accept_addr", ram_a, 32'h100);
    wait_if(lat);
    check("cont_if_latency", lat, 5);
    check("cont_if_inst", if_inst, 32'h0000_0513);
    if_req = 1'b0;
    step();
    step();

    // IO store held while the buffer is full; a pending fetch must not slip in.
    base = ifdone_cnt;
    wlog_n = 0;
    io_buffer_full = 1'b1;
    mem_we = 1'b1; mem_size = 2'b00; mem_signed = 1'b0; mem_addr = 32'h30000;
    mem_wdata = 32'h0000_005A; mem_req = 1'b1;
    if_addr = 32'h100; if_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("io_hold_ram_wr", {31'd0, ram_wr}, 32'd0);
      check("io_hold_mem_stall", {31'd0, mem_stall}, 32'd1);
    end
    io_buffer_full = 1'b0;
    step();
    step();
    check("io_store_done", {31'd0, mem_done}, 32'd1);
    check("io_write_count", wlog_n, 1);
    check("io_write_addr", wlog_a[0], 32'h30000);
    check("io_write_data", {24'd0, wlog_d[0]}, 32'h5A);
    check("io_no_fetch_yet", ifdone_cnt, base);
    mem_req = 1'b0;
    wait_if(lat);
    check("io_then_fetch_seen", {31'd0, lat > 0}, 32'd1);
    check("io_then_fetch_inst", if_inst, 32'h0000_0513);
    if_req = 1'b0;
    step();
    step();

    // Flush on the 2nd IF_RD cycle, then held one idle cycle with if_req still high.
    base = ifdone_cnt;
    if_addr = 32'h100; if_req = 1'b1;
    step();
    step();
    if_flush = 1'b1;
    step();
    check("flush_ram_wr", {31'd0, ram_wr}, 32'd0);
    step();
    if_flush = 1'b0; if_req = 1'b0;
    do_mem(1'b0, 2'b00, 1'b0, 32'h2001, 32'h0, 0, lat, rd);
    check("flush_idle_latency", lat, 2);
    check("flush_idle_rdata", rd, 32'h0000_0080);
    for (int i = 0; i < 6; i++) step();
    check("flush_no_if_done", ifdone_cnt, base);

    // rdy low for two cycles mid-read and mid-store.
    do_mem(1'b0, 2'b10, 1'b0, 32'h2000, 32'h0, 2, lat, rd);
    check("rdy_read_latency", lat, 7);
    check("rdy_read_rdata", rd, 32'h01FF_807F);
    wlog_n = 0;
    do_mem(1'b1, 2'b10, 1'b0, 32'h700, 32'h1122_3344, 2, lat, rd);
    check("rdy_store_latency", lat, 6);
    check("rdy_store_count", wlog_n, 4);
    check("rdy_store_last", {wlog_a[3][15:0], 8'h00, wlog_d[3]}, 32'h0703_0011);
    do_mem(1'b0, 2'b10, 1'b0, 32'h700, 32'h0, 0, lat, rd);
    check("rdy_store_readback", rd, 32'h1122_3344);

    // Reset in the middle of a store.
    base = memdone_cnt;
    mem_we = 1'b1; mem_size = 2'b10; mem_signed = 1'b0; mem_addr = 32'h800;
    mem_wdata = 32'hCAFE_F00D; mem_req = 1'b1;
    step();
    step();
    rst = 1'b1; mem_req = 1'b0;
    step();
    check("mid_rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    check("mid_rst_ram_a", ram_a, 32'h0);
    check("mid_rst_ram_dout", {24'd0, ram_dout}, 32'd0);
    check("mid_rst_done", {30'd0, if_done, mem_done}, 32'd0);
    check("mid_rst_if_inst", if_inst, 32'h0);
    check("mid_rst_mem_rdata", mem_rdata, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("mid_rst_no_done", memdone_cnt, base);
    check("mid_rst_idle_ram_wr", {31'd0, ram_wr}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
